// File: rtl/mem_port_scheduler_if.sv
// Bundle between the memory port scheduler, its three cache requesters and the
// memory controller. master = scheduler side, slave = requesters + controller.
interface mem_port_scheduler_if #(
    parameter int ADDR_W  = 64,
    parameter int BLOCK_W = 512
);
    logic               wb_req;
    logic [ADDR_W-1:0]  wb_addr;
    logic [BLOCK_W-1:0] wb_data;
    logic               wb_done;

    logic               drd_req;
    logic [ADDR_W-1:0]  drd_addr;
    logic               drd_done;

    logic               ird_req;
    logic [ADDR_W-1:0]  ird_addr;
    logic               ird_done;

    logic [BLOCK_W-1:0] rd_data;

    logic               mem_req;
    logic [ADDR_W-1:0]  mem_address;
    logic [BLOCK_W-1:0] mem_data_out;
    logic               mem_wr_en;
    logic               mem_data_valid;
    logic [BLOCK_W-1:0] mem_data_in;

    logic               busy;

    modport master (
        input  wb_req, wb_addr, wb_data, drd_req, drd_addr, ird_req, ird_addr,
               mem_data_valid, mem_data_in,
        output wb_done, drd_done, ird_done, rd_data,
               mem_req, mem_address, mem_data_out, mem_wr_en, busy
    );

    modport slave (
        output wb_req, wb_addr, wb_data, drd_req, drd_addr, ird_req, ird_addr,
               mem_data_valid, mem_data_in,
        input  wb_done, drd_done, ird_done, rd_data,
               mem_req, mem_address, mem_data_out, mem_wr_en, busy
    );
endinterface

// File: rtl/mem_port_scheduler.sv
// Single-port memory scheduler: arbitrates dcache writeback, dcache fill and
// icache fill onto one controller, one transaction at a time, with icache anti-starvation.
module mem_port_scheduler #(
    parameter int ADDR_W     = 64,
    parameter int BLOCK_W    = 512,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_scheduler_if.master  bus
);
    localparam int CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {GNT_WB, GNT_DRD, GNT_IRD} gnt_t;

    state_t             state, state_nxt;
    gnt_t               gnt, win;
    logic               any_req, promote, grant;
    logic [CNT_W-1:0]   starve_cnt;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] wdata_q, rdata_q;
    logic               wr_q;

    // Arbitration: fixed priority unless the icache has lost too many times in a row.
    always_comb begin
        any_req = bus.wb_req | bus.drd_req | bus.ird_req;
        promote = (starve_cnt == CNT_MAX) && bus.ird_req;
        grant   = (state == IDLE) && any_req;
        win     = GNT_IRD;
        if (promote)          win = GNT_IRD;
        else if (bus.wb_req)  win = GNT_WB;
        else if (bus.drd_req) win = GNT_DRD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (bus.mem_data_valid) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req  = (state == ISSUE);
        bus.busy     = (state != IDLE);
        bus.wb_done  = (state == DONE) && (gnt == GNT_WB);
        bus.drd_done = (state == DONE) && (gnt == GNT_DRD);
        bus.ird_done = (state == DONE) && (gnt == GNT_IRD);
    end

    // Request fields are captured once at grant so later requester activity cannot leak in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt     <= GNT_WB;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
        end else if (grant) begin
            gnt  <= win;
            wr_q <= (win == GNT_WB);
            case (win)
                GNT_WB: begin
                    addr_q  <= bus.wb_addr;
                    wdata_q <= bus.wb_data;
                end
                GNT_DRD: addr_q <= bus.drd_addr;
                default: addr_q <= bus.ird_addr;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rdata_q <= '0;
        else if ((state == WAIT) && bus.mem_data_valid && (gnt != GNT_WB))
            rdata_q <= bus.mem_data_in;
    end

    // Counts consecutive grants lost by a waiting icache; only meaningful while it waits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (state == IDLE) begin
            if (!bus.ird_req)
                starve_cnt <= '0;
            else if (win == GNT_IRD)
                starve_cnt <= '0;
            else if (starve_cnt != CNT_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign bus.mem_address  = addr_q;
    assign bus.mem_data_out = wdata_q;
    assign bus.mem_wr_en    = wr_q;
    assign bus.rd_data      = rdata_q;
endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed + randomized bench for mem_port_scheduler; a transaction-level model
// predicts which requester each grant goes to and what the port must show.
module tb_mem_port_scheduler;
    localparam int AW = 64;
    localparam int BW = 512;
    localparam int SM = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_scheduler_if #(.ADDR_W(AW), .BLOCK_W(BW)) bus ();

    mem_port_scheduler #(.ADDR_W(AW), .BLOCK_W(BW), .STARVE_MAX(SM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model state: pending flag / address per requester (0=wb 1=drd 2=ird),
    // wb payload, and how many grants in a row the waiting icache has lost.
    bit            pend [3];
    logic [AW-1:0] addr_m [3];
    logic [BW-1:0] wdata_m;
    int            losses = 0;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_reqs();
        bus.wb_req   = pend[0];
        bus.wb_addr  = addr_m[0];
        bus.wb_data  = wdata_m;
        bus.drd_req  = pend[1];
        bus.drd_addr = addr_m[1];
        bus.ird_req  = pend[2];
        bus.ird_addr = addr_m[2];
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, BW'({bus.mem_req, bus.mem_wr_en, bus.busy,
                                bus.wb_done, bus.drd_done, bus.ird_done}), '0);
        chk({tag, "_addr"}, BW'(bus.mem_address), '0);
        chk({tag, "_wdata"}, bus.mem_data_out, '0);
        chk({tag, "_rdata"}, bus.rd_data, '0);
    endtask

    function automatic int pick();
        if (pend[2] && losses >= SM) return 2;
        if (pend[0]) return 0;
        if (pend[1]) return 1;
        return 2;
    endfunction

    // One full transaction starting from an IDLE cycle with requests already driven.
    task automatic run_one(input int lat, input bit valid_in_issue, input bit move_addr,
                           input logic [BW-1:0] rdat);
        int            exp_id, n;
        logic [AW-1:0] a_hold;
        exp_id = pick();
        if (exp_id == 2)  losses = 0;
        else if (pend[2]) losses = (losses < SM) ? losses + 1 : SM;
        else              losses = 0;

        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.mem_req && n < 8);
        chk("issue_latency", BW'(n), BW'(1));
        chk("mem_address", BW'(bus.mem_address), BW'(addr_m[exp_id]));
        chk("mem_wr_en", BW'(bus.mem_wr_en), BW'(exp_id == 0));
        if (exp_id == 0) chk("mem_data_out", bus.mem_data_out, wdata_m);
        a_hold = addr_m[exp_id];

        if (valid_in_issue) begin
            bus.mem_data_valid = 1'b1;
            bus.mem_data_in    = '1;
        end
        for (int k = 0; k < lat; k++) begin
            @(negedge clk);
            bus.mem_data_valid = 1'b0;
            if (move_addr && k == 0) begin
                addr_m[exp_id] = ~addr_m[exp_id];
                drive_reqs();
            end
            chk("wait_ctl", BW'({bus.busy, bus.mem_req, bus.wb_done, bus.drd_done, bus.ird_done}),
                BW'(5'b10000));
            chk("wait_addr_hold", BW'(bus.mem_address), BW'(a_hold));
        end

        bus.mem_data_in    = rdat;
        bus.mem_data_valid = 1'b1;
        @(negedge clk);
        bus.mem_data_valid = 1'b0;
        chk("done_onehot", BW'({bus.wb_done, bus.drd_done, bus.ird_done}), BW'(3'b100 >> exp_id));
        chk("done_addr_hold", BW'(bus.mem_address), BW'(a_hold));
        if (exp_id != 0) chk("rd_data", bus.rd_data, rdat);
        pend[exp_id] = 1'b0;
        drive_reqs();

        @(negedge clk);
        chk("back_idle", BW'({bus.busy, bus.mem_req, bus.wb_done, bus.drd_done, bus.ird_done}), '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] d;
        for (int r = 0; r < 3; r++) begin
            pend[r]   = 1'b0;
            addr_m[r] = '0;
        end
        wdata_m            = '0;
        bus.mem_data_valid = 1'b0;
        bus.mem_data_in    = '0;
        drive_reqs();

        #2;
        chk_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Single icache fill, controller answers 3 cycles after mem_req.
        pend[2] = 1'b1; addr_m[2] = 64'h1000; drive_reqs();
        run_one(3, 1'b0, 1'b0, {64{8'hA5}});

        // All three at once: wb, then drd, then ird.
        pend[0] = 1'b1; addr_m[0] = 64'h2000; wdata_m = {16{32'hDEADBEEF}};
        pend[1] = 1'b1; addr_m[1] = 64'h3000;
        pend[2] = 1'b1; addr_m[2] = 64'h4000;
        drive_reqs();
        for (int i = 0; i < 3; i++) run_one(1, 1'b0, 1'b0, {16{$urandom()}});

        // Stray controller valid in IDLE must do nothing.
        bus.mem_data_valid = 1'b1;
        @(negedge clk);
        bus.mem_data_valid = 1'b0;
        chk("idle_valid", BW'({bus.busy, bus.wb_done, bus.drd_done, bus.ird_done}), '0);
        @(negedge clk);
        chk("idle_valid_after", BW'({bus.busy, bus.wb_done, bus.drd_done, bus.ird_done}), '0);

        // Stray valid in ISSUE, on a drd fill.
        pend[1] = 1'b1; addr_m[1] = 64'h5040; drive_reqs();
        run_one(2, 1'b1, 1'b0, {16{$urandom()}});

        // drd keeps coming back while ird waits: ird must win the 5th grant.
        pend[2] = 1'b1; addr_m[2] = 64'h6000;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                pend[1] = 1'b1; addr_m[1] = 64'h7000 + 64'(i * 64);
            end
            drive_reqs();
            run_one(1, 1'b0, 1'b0, {16{$urandom()}});
        end
        chk("starve_ird_served", BW'(pend[2]), '0);

        // wb_addr changes during WAIT; the port must keep the granted address.
        pend[0] = 1'b1; addr_m[0] = 64'h8000; wdata_m = {16{$urandom()}}; drive_reqs();
        run_one(3, 1'b0, 1'b1, {16{$urandom()}});

        // Reset in the middle of a wb WAIT: abandoned, no done.
        pend[0] = 1'b1; addr_m[0] = 64'h9000; drive_reqs();
        @(negedge clk);
        chk("rst_txn_issue", BW'(bus.mem_req), BW'(1));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_all_zero("rst_mid");
        pend[0] = 1'b0; losses = 0; drive_reqs();
        @(negedge clk);
        chk("rst_no_done", BW'({bus.wb_done, bus.busy}), '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_release_idle", BW'(bus.busy), '0);
        pend[1] = 1'b1; addr_m[1] = 64'hA000; drive_reqs();
        run_one(1, 1'b0, 1'b0, {16{$urandom()}});

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r]   = 1'b1;
                    addr_m[r] = {$urandom(), $urandom()};
                    if (r == 0) wdata_m = {16{$urandom()}};
                end
            end
            if (!pend[0] && !pend[1] && !pend[2]) begin
                pend[2]   = 1'b1;
                addr_m[2] = {$urandom(), $urandom()};
            end
            drive_reqs();
            d = {16{$urandom()}};
            run_one(int'($urandom_range(1, 3)), bit'($urandom_range(0, 1)), 1'b0, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/mem_port_scheduler.md
MEM_PORT_SCHEDULER -- requirements
Module: mem_port_scheduler

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, request address width.
REQ-002 SHALL have parameter BLOCK_W, default 512, cache-line data width.
REQ-003 SHALL have parameter STARVE_MAX, default 4, the number of consecutive lost arbitrations after which the icache requester is promoted.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports wb_req, input, 1 / wb_addr, input, ADDR_W / wb_data, input, BLOCK_W / wb_done, output, 1: the dcache dirty-line writeback requester.
REQ-007 SHALL have ports drd_req, input, 1 / drd_addr, input, ADDR_W / drd_done, output, 1: the dcache line-fill requester.
REQ-008 SHALL have ports ird_req, input, 1 / ird_addr, input, ADDR_W / ird_done, output, 1: the icache line-fill requester.
REQ-009 SHALL have port rd_data, output, BLOCK_W, the fill line returned to whichever read requester is pulsing done.
REQ-010 SHALL have ports mem_req, output, 1 / mem_address, output, ADDR_W / mem_data_out, output, BLOCK_W / mem_wr_en, output, 1, driving the memory controller.
REQ-011 SHALL have ports mem_data_valid, input, 1 / mem_data_in, input, BLOCK_W, the controller completion and its read data.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-014 In IDLE, with any req high, SHALL grant exactly one requester and go to ISSUE on the next edge; with no req it SHALL stay in IDLE.
REQ-015 Grant priority SHALL be wb > drd > ird, except that when starve_cnt == STARVE_MAX and ird_req is high, ird SHALL win.
REQ-016 On grant, SHALL register the winner id, its address and (wb only) wb_data; mem_address, mem_data_out and mem_wr_en SHALL come from these registers and hold stable until the next grant.
REQ-017 mem_wr_en SHALL be 1 only for a wb grant.
REQ-018 mem_req SHALL be high for exactly one cycle, the ISSUE cycle; ISSUE SHALL go to WAIT unconditionally.
REQ-019 WAIT SHALL hold until mem_data_valid == 1, then go to DONE; on that edge rd_data SHALL capture mem_data_in for read grants.
REQ-020 In DONE, SHALL pulse exactly the granted requester's done for one cycle, then return to IDLE.
REQ-021 Requesters SHALL hold req and request fields until their done and drop req in the done cycle; a req still high in the following IDLE cycle SHALL be treated as a new request.
REQ-022 Request changes after grant SHALL be ignored until the next IDLE.
REQ-023 mem_data_valid in IDLE, ISSUE or DONE SHALL be ignored.
REQ-024 starve_cnt (width clog2(STARVE_MAX+1)) SHALL increment, saturating at STARVE_MAX, on each grant to wb or drd while ird_req is high.
REQ-025 starve_cnt SHALL clear on an ird grant, and in any IDLE cycle with ird_req low.
REQ-026 Minimum latency SHALL be: req seen in IDLE at cycle t, mem_req at t+1, earliest mem_data_valid at t+2, done at t+3.
REQ-027 If all three req rise in the same cycle with starve_cnt < STARVE_MAX, wb SHALL be served first, then drd, then ird.

Reset
REQ-028 On rst low, asynchronously, SHALL set state IDLE, starve_cnt 0, and mem_req, mem_wr_en, busy, wb_done, drd_done, ird_done to 0, and mem_address, mem_data_out, rd_data to 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it with no done pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-030 ird_req=1, addr 0x1000; controller returns valid 3 cycles after mem_req with data 0xA5.. -> one mem_req pulse with mem_wr_en=0, then ird_done for 1 cycle with rd_data=0xA5...
REQ-031 wb_req, drd_req, ird_req all rise together -> mem_address order wb_addr, drd_addr, ird_addr; mem_wr_en=1 only on the first; each done pulses once.
REQ-032 drd_req held high with back-to-back new requests, ird_req high throughout, STARVE_MAX=4 -> ird granted as the 5th transaction.
REQ-033 mem_data_valid pulsed in IDLE and in ISSUE -> no state change and no done pulse.
REQ-034 rst driven low during WAIT of a wb grant -> outputs 0 immediately with no wb_done; after release a new drd_req completes normally.
REQ-035 wb_addr changed during WAIT -> mem_address keeps the granted value until DONE.
